// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ requesters.
// Each grant is a burst that ends on last, at MAX_BURST beats, or on abandon.
// The write enable is gated combinationally by full so no write is ever
// issued while the FIFO is full. One IDLE bubble follows every burst.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] din,
  input  logic                          full,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          w_en,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]   SCAN_MOD = (IDX_W+1)'(NUM_REQ);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [NUM_REQ-1:0]   r_gnt, w_gnt_nxt;
  logic [CNT_W-1:0]     r_beat_cnt, w_beat_cnt_nxt;
  logic [IDX_W-1:0]     r_last_winner, w_last_winner_nxt;
  logic [IDX_W-1:0]     r_gidx, w_gidx_nxt;

  logic [IDX_W:0]       w_scan;
  logic [IDX_W-1:0]     w_winner;
  logic                 w_found;
  logic                 w_req_g;
  logic                 w_last_g;
  logic [DATA_WIDTH-1:0] w_din_g;
  logic                 w_wen;
  logic [NUM_REQ-1:0]   w_ack;
  logic [DATA_WIDTH-1:0] w_wdata;

  // Round-robin search: first requesting index after the previous winner.
  always_comb begin
    w_scan   = '0;
    w_winner = r_last_winner;
    w_found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_scan = {1'b0, r_last_winner} + (IDX_W+1)'(k);
      if (w_scan >= SCAN_MOD) begin
        w_scan = w_scan - SCAN_MOD;
      end else begin
        w_scan = w_scan;
      end
      if (!w_found && req[w_scan[IDX_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_scan[IDX_W-1:0];
      end else begin
        w_found  = w_found;
      end
    end
  end

  // Select the granted requester's request, last flag and data.
  always_comb begin
    w_req_g  = 1'b0;
    w_last_g = 1'b0;
    w_din_g  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gidx == IDX_W'(i)) begin
        w_req_g  = req[i];
        w_last_g = last[i];
        w_din_g  = din[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        w_req_g  = w_req_g;
      end
    end
  end

  // Write port drive: only in BURST, never while full, forced quiet in reset.
  always_comb begin
    w_wen   = 1'b0;
    w_ack   = '0;
    w_wdata = '0;
    if (wrst_n && (r_state == ST_BURST)) begin
      w_wen   = w_req_g & ~full;
      w_wdata = w_din_g;
      if (w_wen) begin
        w_ack = r_gnt;
      end else begin
        w_ack = '0;
      end
    end else begin
      w_wen   = 1'b0;
    end
  end

  // Next-state logic: arbitrate in IDLE, count beats and detect burst end.
  always_comb begin
    w_state_nxt       = r_state;
    w_gnt_nxt         = r_gnt;
    w_beat_cnt_nxt    = r_beat_cnt;
    w_last_winner_nxt = r_last_winner;
    w_gidx_nxt        = r_gidx;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt       = ST_BURST;
          w_gnt_nxt         = NUM_REQ'(1) << w_winner;
          w_last_winner_nxt = w_winner;
          w_gidx_nxt        = w_winner;
          w_beat_cnt_nxt    = '0;
        end else begin
          w_gnt_nxt         = '0;
        end
      end
      ST_BURST: begin
        if (!w_req_g) begin
          // Requester abandoned: nothing is written this cycle.
          w_state_nxt    = ST_IDLE;
          w_gnt_nxt      = '0;
          w_beat_cnt_nxt = '0;
        end else if (w_wen && (w_last_g || (r_beat_cnt == CNT_LAST))) begin
          w_state_nxt    = ST_IDLE;
          w_gnt_nxt      = '0;
          w_beat_cnt_nxt = '0;
        end else if (w_wen) begin
          w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
        end else begin
          // Stalled on full: hold grant and count, no timeout.
          w_beat_cnt_nxt = r_beat_cnt;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_gnt_nxt      = '0;
        w_beat_cnt_nxt = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_state       <= ST_IDLE;
      r_gnt         <= '0;
      r_beat_cnt    <= '0;
      r_last_winner <= IDX_LAST;
      r_gidx        <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_gnt         <= w_gnt_nxt;
      r_beat_cnt    <= w_beat_cnt_nxt;
      r_last_winner <= w_last_winner_nxt;
      r_gidx        <= w_gidx_nxt;
    end
  end

  assign gnt   = r_gnt;
  assign ack   = w_ack;
  assign w_en  = w_wen;
  assign wdata = w_wdata;
  assign busy  = (r_state == ST_BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a transaction-level reference model
// compared every cycle, plus literal expectations for each scenario.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          wclk;
  logic          wrst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  last;
  logic [N*DW-1:0] din;
  logic          full;
  logic [N-1:0]  gnt;
  logic [N-1:0]  ack;
  logic          w_en;
  logic [DW-1:0] wdata;
  logic          busy;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .last(last), .din(din),
    .full(full), .gnt(gnt), .ack(ack), .w_en(w_en), .wdata(wdata), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  // requester behaviour: deliver tot_beats beats, raise last on beat len
  bit       en[N];
  int       tot_beats[N];
  int       len[N];
  logic [7:0] base[N];
  int       acks[N];

  // scoreboard of what actually happened on the write port
  int       gnt_log[$];
  int       wr_idx[$];
  logic [7:0] wr_dat[$];
  int       full_writes;
  logic [N-1:0] prev_gnt;

  // reference model: who holds the port, beats done, previous winner
  bit m_valid = 1'b0;
  bit m_busy;
  int m_g;
  int m_beats;
  int m_lastw;

  logic [N-1:0]  e_gnt;
  logic [N-1:0]  e_ack;
  logic          e_wen;
  logic [DW-1:0] e_wdata;

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int lw);
    for (int k = 1; k <= N; k++) begin
      if (r[(lw + k) % N]) return (lw + k) % N;
    end
    return 0;
  endfunction

  // Reference model advances on each clock edge from the sampled inputs.
  always @(posedge wclk) begin
    if (!wrst_n) begin
      m_valid <= 1'b1;
      m_busy  <= 1'b0;
      m_g     <= 0;
      m_beats <= 0;
      m_lastw <= N - 1;
    end else if (m_valid) begin
      if (!m_busy) begin
        if (req != '0) begin
          m_busy  <= 1'b1;
          m_g     <= pick(req, m_lastw);
          m_lastw <= pick(req, m_lastw);
          m_beats <= 0;
        end
      end else if (!req[m_g]) begin
        m_busy  <= 1'b0;
        m_beats <= 0;
      end else if (!full) begin
        if (last[m_g] || (m_beats + 1 == MB)) begin
          m_busy  <= 1'b0;
          m_beats <= 0;
        end else begin
          m_beats <= m_beats + 1;
        end
      end
    end
  end

  // Compare DUT outputs with the model mid-cycle and log write-port activity.
  always @(negedge wclk) begin
    if (m_valid) begin
      e_gnt   = m_busy ? (N'(1) << m_g) : '0;
      e_wen   = wrst_n && m_busy && req[m_g] && !full;
      e_ack   = e_wen ? e_gnt : '0;
      e_wdata = (wrst_n && m_busy) ? din[m_g*DW +: DW] : '0;
      check("gnt",   gnt,   e_gnt);
      check("busy",  busy,  m_busy);
      check("w_en",  w_en,  e_wen);
      check("ack",   ack,   e_ack);
      check("wdata", wdata, e_wdata);
    end
    if (w_en === 1'b1) begin
      if (full) full_writes++;
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          acks[i]++;
          wr_idx.push_back(i);
        end
      end
      wr_dat.push_back(wdata);
    end
    if (gnt != '0 && prev_gnt == '0) begin
      for (int i = 0; i < N; i++) if (gnt[i]) gnt_log.push_back(i);
    end
    prev_gnt = gnt;
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i]  = en[i] && (acks[i] < tot_beats[i]);
      last[i] = (len[i] != 0) && (acks[i] == len[i] - 1);
      din[i*DW +: DW] = base[i] + 8'(acks[i]);
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
    drive();
  endtask

  task automatic setup(input int i, input int tb, input int ln, input logic [7:0] b);
    en[i] = 1'b1; tot_beats[i] = tb; len[i] = ln; base[i] = b;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b0; tot_beats[i] = 0; len[i] = 0; base[i] = 8'h00; acks[i] = 0;
    end
    gnt_log.delete(); wr_idx.delete(); wr_dat.delete();
    full_writes = 0;
  endtask

  task automatic do_reset(input int n);
    wrst_n = 1'b0;
    repeat (n) step();
    wrst_n = 1'b1;
  endtask

  task automatic quiesce();
    for (int i = 0; i < N; i++) en[i] = 1'b0;
    drive();
    repeat (3) step();
  endtask

  function automatic int count_idx(input int id);
    int c = 0;
    foreach (wr_idx[k]) if (wr_idx[k] == id) c++;
    return c;
  endfunction

  initial begin
    int guard;
    wrst_n = 1'b0; full = 1'b0; req = '0; last = '0; din = '0;
    prev_gnt = '0;
    clear_all();

    // 1: reset held with all requesting
    for (int i = 0; i < N; i++) setup(i, 100, 0, 8'(8'h10 * i));
    drive();
    for (int c = 0; c < 3; c++) begin
      step();
      check("t1_rst_gnt", gnt, 4'b0000);
      check("t1_rst_wen", w_en, 1'b0);
      check("t1_rst_ack", ack, 4'b0000);
      check("t1_rst_wdata", wdata, 8'h00);
      check("t1_rst_busy", busy, 1'b0);
    end
    wrst_n = 1'b1;
    check("t1_release_gnt", gnt, 4'b0000);
    step();
    check("t1_first_gnt", gnt, 4'b0001);
    quiesce();

    // 2: single 3-beat burst from requester 2
    do_reset(2); clear_all();
    setup(2, 3, 3, 8'hA0);
    drive();
    step();
    check("t2_gnt", gnt, 4'b0100);
    repeat (6) step();
    check("t2_nwr", wr_dat.size(), 3);
    if (wr_dat.size() == 3) begin
      check("t2_d0", wr_dat[0], 8'hA0);
      check("t2_d1", wr_dat[1], 8'hA1);
      check("t2_d2", wr_dat[2], 8'hA2);
    end
    check("t2_from2", count_idx(2), 3);
    check("t2_gnt_end", gnt, 4'b0000);
    check("t2_busy_end", busy, 1'b0);
    quiesce();

    // 3: fairness and throughput with all requesting, no last
    do_reset(2); clear_all();
    for (int i = 0; i < N; i++) setup(i, 100, 0, 8'(8'h10 * (i + 1)));
    drive();
    repeat (25) step();
    check("t3_beats25", wr_dat.size(), 20);
    check("t3_ngrants", (gnt_log.size() >= 5) ? 1 : 0, 1);
    if (gnt_log.size() >= 5) begin
      check("t3_order0", gnt_log[0], 0);
      check("t3_order1", gnt_log[1], 1);
      check("t3_order2", gnt_log[2], 2);
      check("t3_order3", gnt_log[3], 3);
      check("t3_order4", gnt_log[4], 0);
    end
    check("t3_from1", count_idx(1), 4);
    quiesce();

    // 4: backpressure during beats 2-3 of requester 1
    do_reset(2); clear_all();
    setup(1, 4, 0, 8'h50);
    drive();
    guard = 0;
    while (acks[1] < 1 && guard < 20) begin step(); guard++; end
    check("t4_wait1", (acks[1] >= 1) ? 1 : 0, 1);
    full = 1'b1;
    #1;
    check("t4_wen_full", w_en, 1'b0);
    check("t4_ack_full", ack, 4'b0000);
    step(); step();
    full = 1'b0;
    guard = 0;
    while (acks[1] < 4 && guard < 20) begin step(); guard++; end
    repeat (2) step();
    check("t4_nwr", wr_dat.size(), 4);
    if (wr_dat.size() == 4) check("t4_d3", wr_dat[3], 8'h53);
    check("t4_no_wr_full", full_writes, 0);
    quiesce();

    // 5: requester 0 abandons after 2 beats, requester 3 waiting
    do_reset(2); clear_all();
    setup(0, 2, 0, 8'h60);
    setup(3, 1, 1, 8'h70);
    drive();
    repeat (12) step();
    check("t5_ngrants", (gnt_log.size() >= 2) ? 1 : 0, 1);
    if (gnt_log.size() >= 2) begin
      check("t5_first", gnt_log[0], 0);
      check("t5_second", gnt_log[1], 3);
    end
    check("t5_from0", count_idx(0), 2);
    check("t5_from3", count_idx(3), 1);
    quiesce();

    // 6: reset in the middle of a requester-2 burst
    do_reset(2); clear_all();
    setup(2, 10, 0, 8'h80);
    drive();
    guard = 0;
    while (acks[2] < 1 && guard < 20) begin step(); guard++; end
    check("t6_wait1", (acks[2] >= 1) ? 1 : 0, 1);
    wrst_n = 1'b0;
    #1;
    check("t6_wen_rst", w_en, 1'b0);
    check("t6_ack_rst", ack, 4'b0000);
    step();
    check("t6_gnt_rst", gnt, 4'b0000);
    check("t6_from2", count_idx(2), 1);
    wrst_n = 1'b1;
    setup(1, 10, 0, 8'h90);
    drive();
    check("t6_req", req, 4'b0110);
    step();
    check("t6_next_gnt", gnt, 4'b0010);
    quiesce();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
